// File: rtl/memory_pkg.sv
// Shared D1 cache helper types: multi-hot sequencer selection policy and a
// population-count helper.
package memory_pkg;

   typedef enum logic {MH_SEQ_PRIO, MH_SEQ_RR} mh_seq_mode_t;

   // Widest vector the popcount helper handles; callers zero-extend into it.
   localparam int unsigned MH_SEQ_MAX_D = 256;

   function automatic int unsigned popcount(input logic [MH_SEQ_MAX_D-1:0] v);
      int unsigned c;
      c = 0;
      for (int unsigned i = 0; i < MH_SEQ_MAX_D; i++) begin
         c = c + 32'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/rr_masked_picker.sv
// Combinational picker: lowest set bit (PRIO) or first set bit at/above ptr
// with wrap to the lowest set bit (RR).
module rr_masked_picker
   import memory_pkg::*;
#(
   parameter int unsigned  D    = 16,
   parameter int unsigned  E    = $clog2(D),
   parameter mh_seq_mode_t MODE = MH_SEQ_PRIO
) (
   input  logic [D-1:0] vec_i,
   input  logic [E-1:0] ptr_i,
   output logic [E-1:0] idx_o,
   output logic [D-1:0] oh_o,
   output logic         any_o
);

   logic [D-1:0] mask;
   logic [D-1:0] cand;
   logic         found;

   always_comb begin
      mask  = '0;
      cand  = '0;
      idx_o = '0;
      oh_o  = '0;
      found = 1'b0;
      any_o = |vec_i;
      // mask = vec & ~((1<<ptr)-1), expressed per bit as i >= ptr
      for (int unsigned i = 0; i < D; i++) begin
         mask[i] = vec_i[i] && (MODE == MH_SEQ_RR) && (E'(i) >= ptr_i);
      end
      cand = (|mask) ? mask : vec_i;
      for (int unsigned i = 0; i < D; i++) begin
         if (cand[i] && !found) begin
            idx_o   = E'(i);
            oh_o[i] = 1'b1;
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_hot_sequencer.sv
// Walks every set bit of a multi-hot vector, emitting one index per accepted
// handshake; pulses done_o once the vector is drained.
module multi_hot_sequencer
   import memory_pkg::*;
#(
   parameter int unsigned  D    = 16,
   parameter int unsigned  E    = $clog2(D),
   parameter mh_seq_mode_t MODE = MH_SEQ_PRIO
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         mh_valid_i,
   output logic         mh_ready_o,
   input  logic [D-1:0] mh_decoded_i,
   output logic         idx_valid_o,
   input  logic         idx_ready_i,
   output logic [E-1:0] idx_o,
   output logic [D-1:0] idx_oh_o,
   output logic         last_o,
   output logic [E:0]   remaining_o,
   output logic         done_o
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e       state_q;
   logic [D-1:0] pending_q, pending_d;
   logic [E-1:0] ptr_q, ptr_d;
   logic         done_q;

   logic [E-1:0] sel_idx;
   logic [D-1:0] sel_oh;
   logic         sel_any;
   logic [E:0]   pop;
   logic         busy, hs, last;

   rr_masked_picker #(
      .D    (D),
      .E    (E),
      .MODE (MODE)
   ) u_picker (
      .vec_i (pending_q),
      .ptr_i (ptr_q),
      .idx_o (sel_idx),
      .oh_o  (sel_oh),
      .any_o (sel_any)
   );

   always_comb begin
      busy      = (state_q == ST_BUSY);
      pop       = (E+1)'(popcount(MH_SEQ_MAX_D'(pending_q)));
      last      = busy && (pop == (E+1)'(1));
      hs        = busy && idx_ready_i && sel_any;
      pending_d = pending_q & ~sel_oh;
      ptr_d     = (sel_idx == E'(D-1)) ? '0 : sel_idx + E'(1);
   end

   assign mh_ready_o  = !busy && !flush_i;
   assign idx_valid_o = busy;
   assign idx_o       = busy ? sel_idx : '0;
   assign idx_oh_o    = busy ? sel_oh : '0;
   assign last_o      = last;
   assign remaining_o = busy ? pop : '0;
   assign done_o      = done_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         ptr_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // flush wins over both accept and drain; ptr_q deliberately kept
         if (flush_i) begin
            pending_q <= '0;
            state_q   <= ST_IDLE;
         end else if (!busy) begin
            if (mh_valid_i) begin
               pending_q <= mh_decoded_i;
               if (|mh_decoded_i) state_q <= ST_BUSY;
               else               done_q  <= 1'b1;
            end
         end else if (hs) begin
            pending_q <= pending_d;
            if (MODE == MH_SEQ_RR) ptr_q <= ptr_d;
            if (last) begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/multi_hot_sequencer.md
# multi_hot_sequencer

Sequential multi-hot to index sequencer for the D1 data cache. It accepts a multi-hot vector, such as a dirty-way mask, valid-line mask or pending-refill mask, and emits the index of every set bit, one per cycle, over a valid/ready handshake. Selection is either fixed-priority (lowest index first) or round-robin with a persistent pointer. Writeback and flush controllers use it to walk all set entries without a combinational N-way mux tree per consumer.

## Interface
Parameters:
- D, 16: input vector width (number of entries); D >= 2.
- E, $clog2(D): encoded index width.
- MODE, MH_SEQ_PRIO: selection policy, MH_SEQ_PRIO or MH_SEQ_RR.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort; drops all pending bits.
- mh_valid_i  in  1  input vector valid.
- mh_ready_o  out  1  sequencer can accept a vector (high only in IDLE).
- mh_decoded_i  in  D  multi-hot input vector.
- idx_valid_o  out  1  idx_o/idx_oh_o valid.
- idx_ready_i  in  1  consumer accepts current index.
- idx_o  out  E  binary index of selected bit.
- idx_oh_o  out  D  one-hot form of idx_o.
- last_o  out  1  current index is the final one of this vector.
- remaining_o  out  E+1  popcount of pending bits, including the current one.
- done_o  out  1  one-cycle pulse: vector fully drained.

## Operation
- State machine: IDLE and BUSY.
- IDLE:
  - mh_ready_o=1, idx_valid_o=0.
  - Accept when mh_valid_i && mh_ready_o; load pending_q <= mh_decoded_i.
  - Nonzero vector -> BUSY.
  - Zero vector -> stay IDLE, pulse done_o next cycle, emit no index.
- BUSY:
  - mh_ready_o=0, idx_valid_o=1.
  - sel = picker(pending_q, ptr_q); idx_o/idx_oh_o are driven from sel.
  - Handshake (idx_valid_o && idx_ready_i):
    - Clear pending_q[sel].
    - RR mode: ptr_q <= (sel==D-1) ? 0 : sel+1.
    - If last_o: -> IDLE, done_o pulses next cycle.
  - Without handshake, all outputs hold stable (no index change while stalled).
- PRIO mode: sel is the lowest set index in pending_q; ptr_q is unused and held at 0.
- RR mode:
  - sel is the first set index at or above ptr_q, wrapping from D-1 to 0.
  - ptr_q persists across vectors (fairness between successive masks).
- last_o = (remaining_o == 1) in BUSY; 0 in IDLE.
- remaining_o is computed combinationally from pending_q; it is 0 in IDLE.
- flush_i:
  - Highest priority; in any state: pending_q <= 0, -> IDLE, no done_o.
  - ptr_q is unchanged.
  - A simultaneous mh_valid_i is not accepted; mh_ready_o is forced 0 while flush_i=1.
- Reset values: state IDLE, pending_q=0, ptr_q=0, done_o=0, idx_valid_o=0, mh_ready_o=1, idx_o=0, idx_oh_o=0, last_o=0, remaining_o=0.
- Reset mid-drain discards pending bits with no done_o.

## Timing
- Accept in cycle t -> idx_valid_o=1 in t+1 (registered input, combinational pick).
- Throughput: one index per cycle while idx_ready_i=1. A K-bit vector drains in cycles t+1..t+K; done_o pulses in t+K+1.
- Next vector can be accepted at t+K+1, the same cycle as the done_o pulse. Its first index appears at t+K+2.
- Zero vector: accept at t, done_o at t+1, mh_ready_o stays 1.
- idx_o, idx_oh_o, last_o and remaining_o are valid only when idx_valid_o=1; otherwise they are 0.

## Structure
- memory_pkg:
  - Add typedef enum logic {MH_SEQ_PRIO, MH_SEQ_RR} mh_seq_mode_t.
  - Add the popcount function used for remaining_o.
- Sub-module rr_masked_picker (combinational, parameters D, E, MODE):
  - Inputs: vector, ptr. Outputs: index, one-hot, any.
  - RR implementation: mask = vector & ~((1<<ptr)-1). Pick the lowest set bit of mask if nonzero, else the lowest set bit of vector.
  - PRIO mode ignores ptr.
- Top level: FSM, pending/ptr registers, done pulse register, popcount.

## Test plan
- PRIO, D=16:
  - Stimulus: accept 16'h8421, idx_ready_i=1.
  - Required: idx_o 0,5,10,15 on t+1..t+4; last_o only with 15; remaining_o 4,3,2,1; done_o at t+5.
- Backpressure:
  - Stimulus: vector 16'h0006, idx_ready_i low for 3 cycles.
  - Required: idx_o=1 held stable with idx_valid_o=1; after release, emits 1 then 2; done_o once.
- RR fairness:
  - Stimulus: vector 16'h0003, then 16'h0003 again.
  - Required: first vector emits 0,1 (ptr_q -> 2); second emits 0,1. Vector 16'h8001 with ptr_q=2 emits 15 then 0.
- Zero vector:
  - Stimulus: accept 16'h0000.
  - Required: idx_valid_o never asserted; done_o pulse at t+1; mh_ready_o stays 1.
- Flush:
  - Stimulus: accept 16'hFFFF, assert flush_i after 3 handshakes, with mh_valid_i=1 in the same cycle.
  - Required: next cycle IDLE, idx_valid_o=0, remaining_o=0, no done_o, vector not accepted.
- Async reset:
  - Stimulus: drop rst_ni mid-drain, asynchronous to clk_i.
  - Required: outputs reach reset values immediately; ptr_q=0; first post-reset RR vector 16'h0010 emits 4.
